// File: rtl/sm83_timer.sv
// SM83 DIV/TIMA/TMA/TAC timer at FF04-FF07: free-running system counter, TAC-selected
// falling-edge tick into TIMA, and a delayed TMA reload that raises the timer IRQ.
module sm83_timer #(
    parameter logic [15:0] ADDR_DIV   = 16'hFF04,
    parameter logic [15:0] ADDR_TIMA  = 16'hFF05,
    parameter logic [15:0] ADDR_TMA   = 16'hFF06,
    parameter logic [15:0] ADDR_TAC   = 16'hFF07,
    parameter int          RELOAD_DLY = 4
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [15:0] bus_addr,
    input  logic [7:0]  bus_wdata,
    input  logic        bus_wr,
    input  logic        bus_rd,
    output logic [7:0]  bus_rdata,
    output logic        bus_hit,
    output logic        irq_timer,
    output logic [1:0]  dbg_state
);

    // Bus protocol: bus_rd / bus_wr are single-cycle strobes qualified by bus_addr;
    // a read is answered on the following cycle with bus_hit high for exactly one cycle.

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        PEND   = 2'd1,
        RELOAD = 2'd2
    } state_t;

    localparam logic [7:0] DLY_INIT = 8'(RELOAD_DLY - 1);

    state_t      state;
    logic [15:0] sys_cnt;
    logic [7:0]  tima;
    logic [7:0]  tma;
    logic [2:0]  tac;
    logic        tbit_q;
    logic [7:0]  dly_cnt;

    logic        sel_bit;
    logic        tbit;
    logic        tick;
    logic        div_wr;
    logic        tima_wr;
    logic        tma_wr;
    logic        tac_wr;
    logic        rd_match;
    logic [7:0]  rd_val;
    logic [7:0]  reload_val;

    always_comb begin
        sel_bit = 1'b0;
        case (tac[1:0])
            2'b00:   sel_bit = sys_cnt[9];
            2'b01:   sel_bit = sys_cnt[3];
            2'b10:   sel_bit = sys_cnt[5];
            default: sel_bit = sys_cnt[7];
        endcase
    end

    // The edge detector sees any 1->0 of the gated bit, so DIV and TAC writes can tick too.
    assign tbit    = tac[2] & sel_bit;
    assign tick    = tbit_q & ~tbit;

    assign div_wr  = bus_wr && (bus_addr == ADDR_DIV);
    assign tima_wr = bus_wr && (bus_addr == ADDR_TIMA);
    assign tma_wr  = bus_wr && (bus_addr == ADDR_TMA);
    assign tac_wr  = bus_wr && (bus_addr == ADDR_TAC);

    // A TMA write landing on the reload cycle is forwarded straight into TIMA.
    assign reload_val = tma_wr ? bus_wdata : tma;

    always_comb begin
        rd_match = 1'b1;
        rd_val   = 8'h00;
        if (bus_addr == ADDR_DIV)       rd_val = sys_cnt[15:8];
        else if (bus_addr == ADDR_TIMA) rd_val = tima;
        else if (bus_addr == ADDR_TMA)  rd_val = tma;
        else if (bus_addr == ADDR_TAC)  rd_val = {5'b11111, tac};
        else                            rd_match = 1'b0;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= IDLE;
            sys_cnt   <= 16'h0000;
            tima      <= 8'h00;
            tma       <= 8'h00;
            tac       <= 3'b000;
            tbit_q    <= 1'b0;
            dly_cnt   <= 8'h00;
            bus_rdata <= 8'h00;
            bus_hit   <= 1'b0;
            irq_timer <= 1'b0;
        end else begin
            sys_cnt   <= div_wr ? 16'h0000 : sys_cnt + 16'd1;
            tbit_q    <= tbit;
            bus_hit   <= bus_rd & rd_match;
            bus_rdata <= (bus_rd & rd_match) ? rd_val : 8'h00;
            irq_timer <= 1'b0;
            if (tma_wr) tma <= bus_wdata;
            if (tac_wr) tac <= bus_wdata[2:0];

            case (state)
                IDLE: begin
                    if (tima_wr) begin
                        tima <= bus_wdata;
                    end else if (tick) begin
                        if (tima == 8'hFF) begin
                            tima    <= 8'h00;
                            dly_cnt <= DLY_INIT;
                            state   <= PEND;
                        end else begin
                            tima <= tima + 8'd1;
                        end
                    end
                end
                PEND: begin
                    if (tima_wr) begin
                        tima  <= bus_wdata;
                        state <= IDLE;
                    end else if (dly_cnt == 8'h00) begin
                        // TIMA shows TMA and the IRQ is high for the whole RELOAD cycle.
                        tima      <= reload_val;
                        irq_timer <= 1'b1;
                        state     <= RELOAD;
                    end else begin
                        dly_cnt <= dly_cnt - 8'd1;
                    end
                end
                RELOAD: begin
                    tima  <= reload_val;
                    state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

    assign dbg_state = state;

endmodule

// File: tb/tb_sm83_timer.sv
// Self-checking bench for sm83_timer: directed timing scenarios, a readback vector table
// and randomized bus traffic, all checked against a cycle-level reference model.
module tb_sm83_timer;

    localparam int DLY = 4;

    logic        clk = 1'b0;
    logic        rst;
    logic [15:0] bus_addr;
    logic [7:0]  bus_wdata;
    logic        bus_wr;
    logic        bus_rd;
    logic [7:0]  bus_rdata;
    logic        bus_hit;
    logic        irq_timer;
    logic [1:0]  dbg_state;

    int n_checks = 0;
    int n_err    = 0;
    int irq_seen = 0;

    // reference model state
    logic [15:0] m_cnt;
    logic [7:0]  m_tima, m_tma;
    logic [2:0]  m_tac;
    logic        m_prev;
    logic        m_pend;
    int          m_age;
    logic        e_hit, e_irq;
    logic [7:0]  e_rdata;

    typedef struct {
        logic        wr;
        logic        rd;
        logic [15:0] addr;
        logic [7:0]  wdata;
        logic        exp_hit;
        logic [7:0]  exp_rdata;
    } vec_t;

    vec_t vecs[16];

    sm83_timer #(.RELOAD_DLY(DLY)) dut (
        .clk       (clk),
        .rst       (rst),
        .bus_addr  (bus_addr),
        .bus_wdata (bus_wdata),
        .bus_wr    (bus_wr),
        .bus_rd    (bus_rd),
        .bus_rdata (bus_rdata),
        .bus_hit   (bus_hit),
        .irq_timer (irq_timer),
        .dbg_state (dbg_state)
    );

    // clock / watchdog
    always #5 clk = ~clk;

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish, checks=%0d", n_checks);
        $fatal(1, "watchdog expired");
    end

    task automatic check(input string name, input logic [7:0] act, input logic [7:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    function automatic int sel_index(input logic [1:0] s);
        case (s)
            2'b00:   return 9;
            2'b01:   return 3;
            2'b10:   return 5;
            default: return 7;
        endcase
    endfunction

    // One bus cycle of the model: outputs expected after the coming clock edge.
    task automatic model_step(input logic r, input logic w, input logic rd,
                              input logic [15:0] a, input logic [7:0] d);
        logic cur, tick, w_div, w_tima, w_tma, w_tac;
        if (r) begin
            m_cnt = 16'h0; m_tima = 8'h0; m_tma = 8'h0; m_tac = 3'b0;
            m_prev = 1'b0; m_pend = 1'b0; m_age = 0;
            e_hit = 1'b0; e_rdata = 8'h00;
        end else begin
            e_hit   = rd && (a >= 16'hFF04) && (a <= 16'hFF07);
            e_rdata = 8'h00;
            if (e_hit) begin
                case (a)
                    16'hFF04: e_rdata = m_cnt[15:8];
                    16'hFF05: e_rdata = m_tima;
                    16'hFF06: e_rdata = m_tma;
                    default:  e_rdata = {5'b11111, m_tac};
                endcase
            end
            cur    = m_tac[2] && m_cnt[sel_index(m_tac[1:0])];
            tick   = m_prev && !cur;
            m_prev = cur;
            w_div  = w && (a == 16'hFF04);
            w_tima = w && (a == 16'hFF05);
            w_tma  = w && (a == 16'hFF06);
            w_tac  = w && (a == 16'hFF07);
            if (m_pend && m_age == DLY) begin
                m_tima = w_tma ? d : m_tma;
                m_pend = 1'b0;
            end else if (m_pend) begin
                if (w_tima) begin
                    m_tima = d;
                    m_pend = 1'b0;
                end else begin
                    if (m_age == DLY - 1) m_tima = w_tma ? d : m_tma;
                    m_age++;
                end
            end else if (w_tima) begin
                m_tima = d;
            end else if (tick) begin
                if (m_tima == 8'hFF) begin
                    m_tima = 8'h00;
                    m_pend = 1'b1;
                    m_age  = 0;
                end else begin
                    m_tima = m_tima + 8'd1;
                end
            end
            m_cnt = w_div ? 16'h0 : m_cnt + 16'd1;
            if (w_tma) m_tma = d;
            if (w_tac) m_tac = d[2:0];
        end
        e_irq = m_pend && (m_age == DLY);
    endtask

    // driver: apply one cycle, step the model, compare after the edge
    task automatic do_cycle(input logic r, input logic w, input logic rd,
                            input logic [15:0] a, input logic [7:0] d);
        rst = r; bus_wr = w; bus_rd = rd; bus_addr = a; bus_wdata = d;
        model_step(r, w, rd, a, d);
        @(posedge clk);
        #1;
        check("hit", 8'(bus_hit), 8'(e_hit));
        check("rdata", bus_rdata, e_rdata);
        check("irq", 8'(irq_timer), 8'(e_irq));
        if (irq_timer) irq_seen++;
    endtask

    task automatic wr(input logic [15:0] a, input logic [7:0] d);
        do_cycle(1'b0, 1'b1, 1'b0, a, d);
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) do_cycle(1'b0, 1'b0, 1'b0, 16'h0000, 8'h00);
    endtask

    task automatic rd_expect(input logic [15:0] a, input logic [7:0] exp, input string name);
        do_cycle(1'b0, 1'b0, 1'b1, a, 8'h00);
        check(name, bus_rdata, exp);
    endtask

    // Reads TIMA every cycle until it returns 00; the last read was made in the first
    // cycle after the overflow, so the next cycle is the second one after it.
    task automatic poll_overflow();
        bit found = 1'b0;
        for (int i = 0; i < 64 && !found; i++) begin
            do_cycle(1'b0, 1'b0, 1'b1, 16'hFF05, 8'h00);
            if (bus_hit && bus_rdata == 8'h00) found = 1'b1;
        end
        if (!found) begin
            n_checks++;
            n_err++;
            $display("FAIL overflow_wait: TIMA did not read 00 within 64 cycles");
        end
    endtask

    initial begin
        int base;
        logic [7:0] d;
        int op;

        vecs[0]  = '{1'b0, 1'b1, 16'hFF04, 8'h00, 1'b1, 8'h00};
        vecs[1]  = '{1'b0, 1'b1, 16'hFF05, 8'h00, 1'b1, 8'h00};
        vecs[2]  = '{1'b0, 1'b1, 16'hFF06, 8'h00, 1'b1, 8'h00};
        vecs[3]  = '{1'b0, 1'b1, 16'hFF07, 8'h00, 1'b1, 8'hF8};
        vecs[4]  = '{1'b0, 1'b1, 16'hFF08, 8'h00, 1'b0, 8'h00};
        vecs[5]  = '{1'b0, 1'b1, 16'hFF03, 8'h00, 1'b0, 8'h00};
        vecs[6]  = '{1'b1, 1'b0, 16'hFF06, 8'h3C, 1'b0, 8'h00};
        vecs[7]  = '{1'b0, 1'b1, 16'hFF06, 8'h00, 1'b1, 8'h3C};
        vecs[8]  = '{1'b1, 1'b0, 16'hFF07, 8'h02, 1'b0, 8'h00};
        vecs[9]  = '{1'b0, 1'b1, 16'hFF07, 8'h00, 1'b1, 8'hFA};
        vecs[10] = '{1'b1, 1'b0, 16'hFF08, 8'h55, 1'b0, 8'h00};
        vecs[11] = '{1'b0, 1'b1, 16'hFF06, 8'h00, 1'b1, 8'h3C};
        vecs[12] = '{1'b1, 1'b0, 16'hFF05, 8'h77, 1'b0, 8'h00};
        vecs[13] = '{1'b0, 1'b1, 16'hFF05, 8'h00, 1'b1, 8'h77};
        vecs[14] = '{1'b0, 1'b0, 16'hFF05, 8'h00, 1'b0, 8'h00};
        vecs[15] = '{1'b0, 1'b1, 16'hFF04, 8'h00, 1'b1, 8'h00};

        // reset, with a read pending to show reset wins
        for (int i = 0; i < 3; i++) do_cycle(1'b1, 1'b0, 1'b1, 16'hFF07, 8'h00);
        check("reset_hit", 8'(bus_hit), 8'h00);
        check("reset_irq", 8'(irq_timer), 8'h00);
        check("reset_state", 8'(dbg_state), 8'h00);

        // tick rate with bit 3
        wr(16'hFF04, 8'h00);
        wr(16'hFF07, 8'h05);
        wr(16'hFF05, 8'h00);
        idle(14);
        rd_expect(16'hFF05, 8'h00, "rate_before_16");
        rd_expect(16'hFF05, 8'h01, "rate_after_16");
        idle(238);
        rd_expect(16'hFF05, 8'h0F, "rate_before_256");
        rd_expect(16'hFF05, 8'h10, "rate_after_256");

        // overflow: four cycles of 00, then TMA with one IRQ pulse
        wr(16'hFF06, 8'hAB);
        wr(16'hFF05, 8'hFF);
        base = irq_seen;
        poll_overflow();
        check("ovf_state_pend", 8'(dbg_state), 8'h01);
        rd_expect(16'hFF05, 8'h00, "ovf_zero_2");
        rd_expect(16'hFF05, 8'h00, "ovf_zero_3");
        rd_expect(16'hFF05, 8'h00, "ovf_zero_4");
        check("ovf_irq_reload", 8'(irq_timer), 8'h01);
        rd_expect(16'hFF05, 8'hAB, "ovf_reload_tma");
        check("ovf_irq_after", 8'(irq_timer), 8'h00);
        idle(4);
        check("ovf_irq_count", 8'(irq_seen - base), 8'h01);

        // cancel by TIMA write two cycles after overflow
        wr(16'hFF05, 8'hFF);
        base = irq_seen;
        poll_overflow();
        idle(1);
        wr(16'hFF05, 8'h42);
        check("cancel_state_idle", 8'(dbg_state), 8'h00);
        rd_expect(16'hFF05, 8'h42, "cancel_tima");
        idle(8);
        check("cancel_irq_count", 8'(irq_seen - base), 8'h00);

        // TMA write in the reload cycle is forwarded
        wr(16'hFF05, 8'hFF);
        base = irq_seen;
        poll_overflow();
        idle(3);
        wr(16'hFF06, 8'h5C);
        rd_expect(16'hFF05, 8'h5C, "reload_tma_fwd");
        check("reload_tma_irq", 8'(irq_seen - base), 8'h01);

        // TIMA write in the reload cycle is ignored
        wr(16'hFF05, 8'hFF);
        poll_overflow();
        idle(3);
        wr(16'hFF05, 8'h99);
        rd_expect(16'hFF05, 8'h5C, "reload_tima_ignored");

        // DIV write while bit 9 is high produces a tick
        wr(16'hFF04, 8'h00);
        wr(16'hFF07, 8'h04);
        wr(16'hFF05, 8'h00);
        idle(510);
        wr(16'hFF04, 8'h12);
        rd_expect(16'hFF05, 8'h00, "div_quirk_before");
        rd_expect(16'hFF05, 8'h01, "div_quirk_tick");
        rd_expect(16'hFF04, 8'h00, "div_cleared");

        // reset during PEND drops the reload and IRQ
        wr(16'hFF07, 8'h05);
        wr(16'hFF05, 8'hFF);
        base = irq_seen;
        poll_overflow();
        idle(1);
        do_cycle(1'b1, 1'b0, 1'b1, 16'hFF05, 8'h00);
        check("rst_pend_hit", 8'(bus_hit), 8'h00);
        check("rst_pend_state", 8'(dbg_state), 8'h00);
        idle(8);
        check("rst_pend_irq_count", 8'(irq_seen - base), 8'h00);

        // readback table
        for (int i = 0; i < 16; i++) begin
            do_cycle(1'b0, vecs[i].wr, vecs[i].rd, vecs[i].addr, vecs[i].wdata);
            check($sformatf("vec%0d_hit", i), 8'(bus_hit), 8'(vecs[i].exp_hit));
            check($sformatf("vec%0d_rdata", i), bus_rdata, vecs[i].exp_rdata);
        end

        // randomized traffic against the model
        for (int i = 0; i < 2500; i++) begin
            if ($urandom_range(0, 499) == 0) begin
                do_cycle(1'b1, 1'b0, 1'b0, 16'h0000, 8'h00);
            end else begin
                op = int'($urandom_range(0, 11));
                case (op)
                    5, 6: do_cycle(1'b0, 1'b0, 1'b1, 16'hFF03 + 16'($urandom_range(0, 5)), 8'h00);
                    7: begin
                        if ($urandom_range(0, 2) == 0) d = 8'($urandom_range(0, 255));
                        else d = ($urandom_range(0, 1) != 0) ? 8'hFF : 8'hFE;
                        wr(16'hFF05, d);
                    end
                    8: begin
                        d = 8'($urandom_range(0, 255));
                        if ($urandom_range(0, 3) != 0) d[2] = 1'b1;
                        wr(16'hFF07, d);
                    end
                    9: wr(16'hFF06, 8'($urandom_range(0, 255)));
                    10: begin
                        if ($urandom_range(0, 7) == 0) wr(16'hFF04, 8'($urandom_range(0, 255)));
                        else do_cycle(1'b0, 1'b0, 1'b1, 16'hFF05, 8'h00);
                    end
                    11: wr(16'hFF03 + 16'($urandom_range(0, 5)), 8'($urandom_range(0, 255)));
                    default: idle(1);
                endcase
            end
        end
        idle(2);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
        $finish;
    end

endmodule
